l1_mmu_arb: RTL and testbench
=============================

L1_MMU_ARB -- requirements
Module: l1_mmu_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of L1 requesters (I-cache, D-cache), range 1-4.
REQ-002 SHALL have parameter LINE_WORDS, default 8, 32-bit words per cache line; power of two, 2-16; LINE_BITS = 32*LINE_WORDS.
REQ-003 SHALL have parameters MMIO_BASE, default 32'hFFFF0000, and MMIO_MASK, default 32'hFFFF0000; an address is MMIO when (addr & MMIO_MASK) == MMIO_BASE.
REQ-004 SHALL have ports: sys_clk in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have L1-side ports: l1_mmu_req_read in NUM_PORTS; l1_mmu_req_write in NUM_PORTS; l1_mmu_req_addr in 32*NUM_PORTS, port p at [32p+31:32p]; l1_mmu_write_data in LINE_BITS*NUM_PORTS.
REQ-006 SHALL have L1-side outputs: mmu_l1_read_done out NUM_PORTS; mmu_l1_write_done out NUM_PORTS; mmu_l1_read_data out LINE_BITS, shared by all ports.
REQ-007 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_ack in 1, one per word transferred; mem_rdata in 32, valid with mem_ack.
REQ-008 SHALL have MMIO ports: mmu_mmio_read out 1; mmu_mmio_write out 1; mmu_mmio_addr out 32; mmu_mmio_wdata out 32; mmu_mmio_hit in 1; mmu_mmio_data in 32.

Function
REQ-009 SHALL use FSM states IDLE, MEM_RD, MEM_WR, MMIO, DONE.
REQ-010 A requester SHALL hold its req level and its addr/data stable until its done pulse; done SHALL be a one-cycle pulse.
REQ-011 In IDLE, the FSM SHALL grant one pending port round-robin, starting after the last-granted port (port 0 first after reset), latch its addr/data, and leave IDLE the next cycle.
REQ-012 If one port asserts read and write together, the FSM SHALL serve the write first and the read in a later grant.
REQ-013 Memory line transfers SHALL be line-aligned: mem_addr = {addr[31:log2(LINE_BITS/8)], word index, 2'b00}, word index incrementing 0..LINE_WORDS-1.
REQ-014 In MEM_RD/MEM_WR, mem_req SHALL be held high; each mem_ack cycle SHALL transfer one word and advance the index; mem_we SHALL be 1 only in MEM_WR; mem_wdata SHALL be the latched word for the current index.
REQ-015 After the last ack, the FSM SHALL enter DONE, drop mem_req, and pulse the granted port's done while driving mmu_l1_read_data for reads; latency = LINE_WORDS acks + 2 cycles from grant.
REQ-016 An MMIO access SHALL be a single word selected by addr[log2(LINE_WORDS)+1:2]: one cycle in MMIO with mmu_mmio_read or mmu_mmio_write high, mmu_mmio_addr = word-aligned addr, and mmu_mmio_wdata = the selected word of write data.
REQ-017 For an MMIO read with hit, the returned line SHALL be mmu_mmio_data in the selected word and zeros elsewhere; with hit low, the line SHALL be all zeros; done SHALL pulse in either case.
REQ-018 mmu_l1_read_data SHALL hold its last value between transactions.
REQ-019 The FSM SHALL return from DONE to IDLE; back-to-back grants SHALL have at least one IDLE cycle between them.

Reset
REQ-020 While rst is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the round-robin pointer SHALL point to port 0.
REQ-021 rst asserted mid-transaction SHALL abort it: no done pulse, mem_req low the following cycle, and the transaction SHALL not be resumed.

Configuration
REQ-022 With macro L1_MMU_MMIO_EN defined, MMIO decode per REQ-003/REQ-016/REQ-017 SHALL apply; without it, every address SHALL go to memory and the mmu_mmio_* outputs SHALL be tied to 0.

Verification
REQ-023 Port 0 read at 0x00000124, LINE_WORDS=8 -> mem_addr 0x120..0x13C; on the 8th ack, read_done[0] pulses with the assembled 256-bit line.
REQ-024 Ports 0 and 1 both request reads in the same cycle after reset -> port 0 is served first, then port 1; on a repeated simultaneous request, port 1 is served before port 0.
REQ-025 Port 1 write of line 0x0000_0040 with word k = k -> 8 beats with mem_we=1 and mem_wdata 0..7; write_done[1] pulses.
REQ-026 With L1_MMU_MMIO_EN, read at 0xFFFF0008 with hit=1 and data 0xDEADBEEF -> line word 2 = 0xDEADBEEF, other words 0; with hit=0 -> all zeros, done still pulses.
REQ-027 rst asserted after the 3rd ack of a read -> no done pulse, mem_req low next cycle, outputs 0; a new request after reset completes normally.
REQ-028 Port 0 asserts read and write together -> write_done[0] pulses first, then read_done[0] in a later grant.

Source files
------------

// File: rtl/l1_mmu_arb.sv
// l1_mmu_arb: round-robin arbiter moving L1 cache lines over a word-wide memory bus.
// Define L1_MMU_MMIO_EN to route MMIO-window addresses to the single-word MMIO port.
module l1_mmu_arb #(
  parameter int          NUM_PORTS  = 2,
  parameter int          LINE_WORDS = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000,
  parameter logic [31:0] MMIO_MASK  = 32'hFFFF0000
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          l1_mmu_req_read,
  input  logic [NUM_PORTS-1:0]          l1_mmu_req_write,
  input  logic [32*NUM_PORTS-1:0]       l1_mmu_req_addr,
  input  logic [32*LINE_WORDS*NUM_PORTS-1:0]
                                        l1_mmu_write_data,
  output logic [NUM_PORTS-1:0]          mmu_l1_read_done,
  output logic [NUM_PORTS-1:0]          mmu_l1_write_done,
  output logic [32*LINE_WORDS-1:0]      mmu_l1_read_data,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          mmu_mmio_read,
  output logic                          mmu_mmio_write,
  output logic [31:0]                   mmu_mmio_addr,
  output logic [31:0]                   mmu_mmio_wdata,
  input  logic                          mmu_mmio_hit,
  input  logic [31:0]                   mmu_mmio_data
);

  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int IW  = $clog2(LINE_WORDS);
  localparam int OFF = IW + 2;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, MEM_RD, MEM_WR, MMIO, DONE
  } state_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        gnt_q, pick, hi, lo;
  logic                 hi_v, lo_v, found;
  logic                 wr_q, pick_wr, pick_mmio;
  logic [31:0]          addr_q, pick_addr;
  logic [IW-1:0]        idx_q;
  line_t                buf_q, rd_q, mmio_line;
  logic [NUM_PORTS-1:0] pend;

  assign pend = l1_mmu_req_read | l1_mmu_req_write;

  // First pending port above the last grant wins, else lowest at/below it.
  always_comb begin
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi   = '0;
    lo   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (pend[p]) begin
        if (p > int'(gnt_q)) begin
          hi_v = 1'b1;
          hi   = PW'(p);
        end else begin
          lo_v = 1'b1;
          lo   = PW'(p);
        end
      end
    end
    found = hi_v | lo_v;
    pick  = hi_v ? hi : lo;
  end

  assign pick_addr = l1_mmu_req_addr[32*pick +: 32];
  assign pick_wr   = l1_mmu_req_write[pick];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (found) begin
        if (pick_mmio)    state_d = MMIO;
        else if (pick_wr) state_d = MEM_WR;
        else              state_d = MEM_RD;
      end
      MEM_RD, MEM_WR:
        if (mem_ack && idx_q == LAST_IDX)
          state_d = DONE;
      MMIO:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= PW'(NUM_PORTS - 1);
      wr_q    <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (found) begin
          gnt_q  <= pick;
          wr_q   <= pick_wr;
          addr_q <= pick_addr;
          idx_q  <= '0;
          buf_q  <= l1_mmu_write_data[LINE_BITS*pick +: LINE_BITS];
        end
        MEM_RD: if (mem_ack) begin
          buf_q[idx_q] <= mem_rdata;
          idx_q        <= idx_q + 1'b1;
        end
        MEM_WR: if (mem_ack) idx_q <= idx_q + 1'b1;
        MMIO:   if (!wr_q) buf_q <= mmio_line;
        DONE:   if (!wr_q) rd_q <= buf_q;
        default: ;
      endcase
    end
  end

  assign mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign mem_we    = state_q == MEM_WR;
  assign mem_addr  = mem_req ? {addr_q[31:OFF], idx_q, 2'b00} : '0;
  assign mem_wdata = mem_we ? buf_q[idx_q] : '0;

  // The fresh line is presented in DONE; rd_q keeps it afterwards.
  assign mmu_l1_read_data = (state_q == DONE && !wr_q) ? buf_q : rd_q;

  always_comb begin
    mmu_l1_read_done  = '0;
    mmu_l1_write_done = '0;
    if (state_q == DONE) begin
      if (wr_q) mmu_l1_write_done[gnt_q] = 1'b1;
      else      mmu_l1_read_done[gnt_q]  = 1'b1;
    end
  end

`ifdef L1_MMU_MMIO_EN
  logic [IW-1:0] sel;
  logic          unused_lsb;

  assign pick_mmio = (pick_addr & MMIO_MASK) == MMIO_BASE;
  assign sel       = addr_q[OFF-1:2];

  always_comb begin
    mmio_line = '0;
    if (mmu_mmio_hit) mmio_line[sel] = mmu_mmio_data;
  end

  assign mmu_mmio_read  = (state_q == MMIO) && !wr_q;
  assign mmu_mmio_write = (state_q == MMIO) && wr_q;
  assign mmu_mmio_addr  = (state_q == MMIO) ? {addr_q[31:2], 2'b00} : '0;
  assign mmu_mmio_wdata = mmu_mmio_write ? buf_q[sel] : '0;
  assign unused_lsb     = ^addr_q[1:0];
`else
  logic unused_mmio;

  assign pick_mmio      = 1'b0;
  assign mmio_line      = '0;
  assign mmu_mmio_read  = 1'b0;
  assign mmu_mmio_write = 1'b0;
  assign mmu_mmio_addr  = '0;
  assign mmu_mmio_wdata = '0;
  assign unused_mmio    = ^{mmu_mmio_hit, mmu_mmio_data, addr_q[OFF-1:0]};
`endif

endmodule

// File: tb/tb_l1_mmu_arb.sv
// tb_l1_mmu_arb: directed and random line transfers checked against a
// word-addressed reference memory held in the bench.
`timescale 1ns/1ps
module tb_l1_mmu_arb;
  localparam int NP = 2;
  localparam int LW = 8;
  localparam int LB = 32 * LW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] rd_r = '0;
  logic [NP-1:0] wr_r = '0;
  logic [32*NP-1:0] addr_r = '0;
  logic [LB*NP-1:0] wd_r = '0;
  logic [NP-1:0] rdone, wdone;
  logic [LB-1:0] rdata;
  logic          mem_req, mem_we;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_addr, mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mmio_rd, mmio_wr;
  logic          mmio_hit = 1'b0;
  logic [31:0]   mmio_addr, mmio_wdata;
  logic [31:0]   mmio_data = '0;

  always #5 clk = ~clk;

  l1_mmu_arb #(.NUM_PORTS(NP), .LINE_WORDS(LW)) dut (
    .sys_clk           (clk),
    .rst               (rst),
    .l1_mmu_req_read   (rd_r),
    .l1_mmu_req_write  (wr_r),
    .l1_mmu_req_addr   (addr_r),
    .l1_mmu_write_data (wd_r),
    .mmu_l1_read_done  (rdone),
    .mmu_l1_write_done (wdone),
    .mmu_l1_read_data  (rdata),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .mmu_mmio_read     (mmio_rd),
    .mmu_mmio_write    (mmio_wr),
    .mmu_mmio_addr     (mmio_addr),
    .mmu_mmio_wdata    (mmio_wdata),
    .mmu_mmio_hit      (mmio_hit),
    .mmu_mmio_data     (mmio_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [LB-1:0] obs,
                     input logic [LB-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ 16'h3C5A};
  endfunction

  // Memory device on the bus, and the bench's own expectation of memory.
  logic [31:0] dev_m [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];
  logic [31:0] b_addr[$];
  logic [31:0] b_wdata[$];
  logic        b_we[$];

  always @(posedge clk) begin
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (mem_req && !rst && $urandom_range(3) != 0) begin
      mem_ack = 1'b1;
      b_addr.push_back(mem_addr);
      b_we.push_back(mem_we);
      b_wdata.push_back(mem_wdata);
      if (mem_we) dev_m[mem_addr] = mem_wdata;
      else mem_rdata = dev_m.exists(mem_addr) ? dev_m[mem_addr]
                                              : init_word(mem_addr);
    end
  end

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  function automatic logic [LB-1:0] ref_line(input logic [31:0] a);
    logic [LB-1:0] l;
    logic [31:0]   w;
    for (int k = 0; k < LW; k++) begin
      w = base_of(a) + 32'(4 * k);
      l[k*32 +: 32] = ref_m.exists(w) ? ref_m[w] : init_word(w);
    end
    return l;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [LB-1:0] l);
    for (int k = 0; k < LW; k++)
      ref_m[base_of(a) + 32'(4 * k)] = l[k*32 +: 32];
  endtask

  typedef struct {
    int            port;
    bit            wr;
    logic [LB-1:0] data;
  } ev_t;

  ev_t         evq[$];
  int          mmio_seen;
  logic [31:0] mmio_addr_seen, mmio_wdata_seen;
  logic        mmio_wr_seen;

  task automatic clear_log();
    b_addr.delete();
    b_we.delete();
    b_wdata.delete();
    evq.delete();
    mmio_seen = 0;
  endtask

  // Acts as the L1s: holds requests until done, optionally re-requesting
  // on port 0 right after its first read completes.
  task automatic serve(input bit rearm0, input logic [31:0] rearm_addr);
    int n;
    bit arm;
    n = 0;
    arm = rearm0;
    while ((rd_r != 0 || wr_r != 0) && n < 400) begin
      @(negedge clk);
      n++;
      if (mmio_rd || mmio_wr) begin
        mmio_seen++;
        mmio_addr_seen  = mmio_addr;
        mmio_wdata_seen = mmio_wdata;
        mmio_wr_seen    = mmio_wr;
      end
      for (int p = 0; p < NP; p++) begin
        if (wdone[p]) begin
          chk($sformatf("wdone_expected_p%0d", p), LB'(wr_r[p]), LB'(1));
          evq.push_back('{p, 1'b1, rdata});
          wr_r[p] = 1'b0;
        end
        if (rdone[p]) begin
          chk($sformatf("rdone_expected_p%0d", p), LB'(rd_r[p]), LB'(1));
          evq.push_back('{p, 1'b0, rdata});
          if (arm && p == 0) begin
            arm = 1'b0;
            addr_r[31:0] = rearm_addr;
          end else begin
            rd_r[p] = 1'b0;
          end
        end
      end
    end
    chk("serve_timeout", LB'({rd_r, wr_r}), '0);
  endtask

  task automatic expect_ev(input string tag, input int port, input bit wr,
                           input logic [LB-1:0] line);
    ev_t e;
    e.port = -1;
    e.wr   = 1'b0;
    e.data = '0;
    if (evq.size() != 0) e = evq.pop_front();
    chk({tag, "_port"}, LB'(e.port), LB'(port));
    chk({tag, "_kind"}, LB'(e.wr), LB'(wr));
    chk({tag, "_data"}, e.data, line);
  endtask

  task automatic expect_beats(input string tag, input logic [31:0] a,
                              input bit we, input logic [LB-1:0] line);
    logic [31:0] wd;
    chk({tag, "_nbeats"}, LB'(b_addr.size()), LB'(LW));
    for (int k = 0; k < LW && k < b_addr.size(); k++) begin
      wd = b_we[k] ? b_wdata[k] : 32'h0;
      chk($sformatf("%s_beat%0d", tag, k),
          LB'({b_we[k], b_addr[k], wd}),
          LB'({we, base_of(a) + 32'(4 * k), we ? line[k*32 +: 32] : 32'h0}));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [LB-1:0] last_rd, l_i;
  logic [31:0]   a_i;
  int            p_i, n;
  bit            w_i;

  initial begin
    last_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", LB'({mem_req, mem_we, mem_addr, mem_wdata, rdone,
        wdone, mmio_rd, mmio_wr, mmio_addr, mmio_wdata}), '0);
    chk("rst_rdata", rdata, '0);
    rst = 1'b0;

    // Simultaneous reads after reset, port 0 re-requesting immediately.
    clear_log();
    addr_r = {32'h0000_0200, 32'h0000_0100};
    rd_r = 2'b11;
    serve(1'b1, 32'h0000_0300);
    expect_ev("rr_first", 0, 1'b0, ref_line(32'h100));
    expect_ev("rr_second", 1, 1'b0, ref_line(32'h200));
    expect_ev("rr_third", 0, 1'b0, ref_line(32'h300));

    clear_log();
    addr_r = {32'h0000_0280, 32'h0000_0180};
    rd_r = 2'b11;
    serve(1'b0, 32'h0);
    expect_ev("rr_rep_first", 1, 1'b0, ref_line(32'h280));
    expect_ev("rr_rep_second", 0, 1'b0, ref_line(32'h180));
    last_rd = ref_line(32'h180);

    // Unaligned read fetches the whole aligned line.
    clear_log();
    addr_r[31:0] = 32'h0000_0124;
    rd_r = 2'b01;
    serve(1'b0, 32'h0);
    expect_ev("rd124", 0, 1'b0, ref_line(32'h124));
    expect_beats("rd124", 32'h120, 1'b0, '0);
    last_rd = ref_line(32'h124);
    @(negedge clk);
    chk("rdata_hold", rdata, last_rd);

    // Port 1 writes word k = k; read data output must not move.
    clear_log();
    for (int k = 0; k < LW; k++) l_i[k*32 +: 32] = 32'(k);
    wd_r[LB +: LB] = l_i;
    addr_r[63:32] = 32'h0000_0040;
    wr_r = 2'b10;
    serve(1'b0, 32'h0);
    expect_ev("wr40", 1, 1'b1, last_rd);
    expect_beats("wr40", 32'h40, 1'b1, l_i);
    ref_write(32'h40, l_i);

    clear_log();
    addr_r[31:0] = 32'h0000_005C;
    rd_r = 2'b01;
    serve(1'b0, 32'h0);
    expect_ev("rd40_back", 0, 1'b0, ref_line(32'h40));
    last_rd = ref_line(32'h40);

    // Read and write together: write lands first, read sees it.
    clear_log();
    for (int k = 0; k < LW; k++) l_i[k*32 +: 32] = $urandom;
    wd_r[0 +: LB] = l_i;
    addr_r[31:0] = 32'h0000_0088;
    rd_r = 2'b01;
    wr_r = 2'b01;
    serve(1'b0, 32'h0);
    ref_write(32'h88, l_i);
    expect_ev("rw_write", 0, 1'b1, last_rd);
    expect_ev("rw_read", 0, 1'b0, l_i);
    last_rd = l_i;

    // MMIO-window address.
    clear_log();
`ifdef L1_MMU_MMIO_EN
    mmio_hit = 1'b1;
    mmio_data = 32'hDEAD_BEEF;
    addr_r[31:0] = 32'hFFFF_0008;
    rd_r = 2'b01;
    serve(1'b0, 32'h0);
    l_i = '0;
    l_i[2*32 +: 32] = 32'hDEAD_BEEF;
    expect_ev("mmio_hit", 0, 1'b0, l_i);
    chk("mmio_addr", LB'(mmio_addr_seen), LB'(32'hFFFF_0008));
    chk("mmio_cycles", LB'(mmio_seen), LB'(1));
    chk("mmio_no_mem", LB'(b_addr.size()), '0);
    clear_log();
    mmio_hit = 1'b0;
    rd_r = 2'b01;
    serve(1'b0, 32'h0);
    expect_ev("mmio_miss", 0, 1'b0, '0);
    clear_log();
    for (int k = 0; k < LW; k++) l_i[k*32 +: 32] = $urandom;
    wd_r[LB +: LB] = l_i;
    addr_r[63:32] = 32'hFFFF_0014;
    wr_r = 2'b10;
    serve(1'b0, 32'h0);
    expect_ev("mmio_wr", 1, 1'b1, '0);
    chk("mmio_wr_word", LB'({mmio_wr_seen, mmio_addr_seen, mmio_wdata_seen}),
        LB'({1'b1, 32'hFFFF_0014, l_i[5*32 +: 32]}));
    last_rd = '0;
`else
    addr_r[31:0] = 32'hFFFF_0008;
    rd_r = 2'b01;
    serve(1'b0, 32'h0);
    expect_ev("mmio_off", 0, 1'b0, ref_line(32'hFFFF_0008));
    expect_beats("mmio_off", 32'hFFFF_0000, 1'b0, '0);
    chk("mmio_off_quiet", LB'(mmio_seen), '0);
    last_rd = ref_line(32'hFFFF_0008);
`endif

    // Reset after the third ack aborts the read.
    clear_log();
    addr_r[31:0] = 32'h0000_01A4;
    rd_r = 2'b01;
    n = 0;
    while (b_addr.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_acks", LB'(b_addr.size()), LB'(3));
    @(negedge clk);
    rst = 1'b1;
    rd_r = '0;
    chk("abort_nodone_pre", LB'({rdone, wdone}), '0);
    @(negedge clk);
    chk("abort_outputs", LB'({mem_req, mem_we, mem_addr, mem_wdata, rdone,
        wdone, mmio_rd, mmio_wr}), '0);
    chk("abort_rdata", rdata, '0);
    rst = 1'b0;
    last_rd = '0;
    clear_log();
    addr_r[63:32] = 32'h0000_01A4;
    rd_r = 2'b10;
    serve(1'b0, 32'h0);
    expect_ev("after_rst", 1, 1'b0, ref_line(32'h1A4));
    expect_beats("after_rst", 32'h1A0, 1'b0, '0);
    last_rd = ref_line(32'h1A4);

    // Random single-port traffic against the reference memory.
    for (int i = 0; i < 24; i++) begin
      p_i = $urandom_range(NP - 1);
      w_i = 1'($urandom_range(1));
      a_i = 32'($urandom_range(31)) * 32 + 32'($urandom_range(7)) * 4;
      for (int k = 0; k < LW; k++) l_i[k*32 +: 32] = $urandom;
      clear_log();
      addr_r[32*p_i +: 32] = a_i;
      if (w_i) begin
        wd_r[LB*p_i +: LB] = l_i;
        wr_r[p_i] = 1'b1;
      end else begin
        rd_r[p_i] = 1'b1;
      end
      serve(1'b0, 32'h0);
      if (w_i) begin
        expect_ev("rnd_wr", p_i, 1'b1, last_rd);
        expect_beats("rnd_wr", a_i, 1'b1, l_i);
        ref_write(a_i, l_i);
      end else begin
        expect_ev("rnd_rd", p_i, 1'b0, ref_line(a_i));
        expect_beats("rnd_rd", a_i, 1'b0, '0);
        last_rd = ref_line(a_i);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
